bmp_header_writer: RTL
======================

Name: bmp_header_writer

Overview:
- Parametrised successor to the cropping-path BMP header generator: emits the 54-byte BITMAPINFOHEADER-format header for a cropped region into the frame/file memory.
- Adds configurable data-bus width with byte packing, 24/32 bpp mode, top-down orientation, a base address, a memory wait-request handshake, input snapshotting and crop-window error detection.
- Sits between the crop-bounds logic and the SDRAM/file-buffer write port. The pixel writer starts after `done`.

Parameters:
- ADDR_W, 24, width of `addr`.
- DATA_W, 16, write-bus width; legal values are 8, 16 and 32. BPW = DATA_W/8 bytes per word.
- COORD_W, 11, width of the crop coordinates.
- BASE_ADDR, 0, word address of header byte 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled in IDLE or DONE.
- xMin, xMax, yMin, yMax  in  COORD_W each  inclusive crop bounds.
- bpp32  in  1  0 selects 24 bpp, 1 selects 32 bpp.
- top_down  in  1  1 writes a negative height.
- wait_req  in  1  memory stall; while high, the current write is not accepted.
- addr  out  ADDR_W  word address.
- wren  out  1  write strobe.
- wrdata  out  DATA_W  packed header bytes, little-endian.
- byteen  out  BPW  byte enables.
- busy  out  1  high in CALC and WRITE.
- done  out  1  high in DONE.
- err  out  1  high in DONE when the crop window was invalid.

Behaviour:
- Reset: asynchronous. Forces IDLE and clears the counter. All outputs are 0. Reset mid-write abandons the header with no further writes.

State machine:
- IDLE: on start, latch all inputs and go to CALC.
- CALC (1 cycle): compute the registered fields. If xMax<xMin or yMax<yMin, set err and go to DONE with no writes. Otherwise clear err and go to WRITE.
- WRITE: present word k (k = 0..NW-1) with wren=1 and addr = BASE_ADDR+k.
  - If wait_req=1: hold addr, wrdata, byteen and k.
  - If wait_req=0: the word is accepted. Increment k; after word NW-1 go to DONE.
- DONE: done=1, held until the next start. start here behaves as in IDLE.
- start in CALC or WRITE is ignored. Inputs that change after the snapshot have no effect.

Field arithmetic (unsigned 32-bit, all values zero-extended):
- W = xMax-xMin+1; H = yMax-yMin+1.
- raw = 3W or 4W; stride = (raw+3) & ~3.
- img = stride*H; fsize = img+54.
- Height field = H, or -H (32-bit two's complement) when top_down=1.
- bpp field = 24 or 32.

Byte map (little-endian):
- 0-1: "BM" (0x42, 0x4D).
- 2-5: fsize.
- 6-9: 0.
- 10-13: 54.
- 14-17: 40.
- 18-21: W.
- 22-25: height field.
- 26-27: 1.
- 28-29: bpp.
- 30-33: 0.
- 34-37: img.
- 38-53: 0.

Packing:
- NW = ceil(54/BPW), giving 54, 27 or 14 words.
- Word k holds bytes k*BPW .. k*BPW+BPW-1, with the lowest byte in bits [7:0].
- Bytes at index ≥54 are 0 with byteen=0. For DATA_W=32, the last word has byteen=4'b0011. All other words have all enables set.

Latency and outputs:
- The first wren occurs 2 cycles after start is sampled.
- With no stalls, WRITE lasts NW cycles.
- done rises the cycle after the last accepted word.
- Outside WRITE: wren, addr, wrdata and byteen are 0.

Decomposition:
- Package bmp_pkg holds:
  - the state enum;
  - constants HDR_BYTES=54, DIB_SIZE=40, PIX_OFFSET=54, SIG_B=8'h42, SIG_M=8'h4D;
  - the function `stride_bytes(w, bpp32)`.
- Sub-module bmp_header_rom: combinational byte-index→byte lookup over the registered fields. The top level packs BPW lookups per word.

Test Plan:
- DATA_W=8, x 0..99, y 0..99, 24 bpp -> 54 writes at addr 0..53.
  - Bytes 2-5 = 66 75 00 00 (30054).
  - Bytes 18-21 = 64 00 00 00.
  - Bytes 34-37 = 30 75 00 00.
  - Byte 28 = 0x18.
  - done on the cycle after addr 53.
- DATA_W=16, x 10..14 (W=5), y 0..1, 24 bpp -> 27 writes, word0 = 0x4D42.
  - stride 16, img 32, fsize 86: word1 = 0x0056.
  - Bytes 34-35 = 0x20.
- Same window, 32 bpp, top_down=1 -> stride 20, img 40, fsize 94.
  - Bytes 22-25 = FE FF FF FF.
  - Byte 28 = 0x20.
- DATA_W=32 -> 14 writes; the last word at BASE_ADDR+13 has byteen=0011 and bits [31:16]=0.
  - Holding wait_req high 3 cycles on word 4 holds addr/data steady, and total WRITE time becomes 17 cycles.
- xMax=5, xMin=9 -> no wren ever; done=1 and err=1 two cycles after start. A following valid start clears err and writes normally.
- Assert rst during word 10 -> outputs are 0 immediately with no further wren. The next start writes all bytes from word 0.

Source files
------------

// File: rtl/bmp_pkg.sv
// Shared types, header constants and row-stride helper for the BMP header writer.
package bmp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_WRITE,
        S_DONE
    } state_e;

    localparam int          HDR_BYTES  = 54;
    localparam logic [31:0] DIB_SIZE   = 32'd40;
    localparam logic [31:0] PIX_OFFSET = 32'd54;
    localparam logic [7:0]  SIG_B      = 8'h42;
    localparam logic [7:0]  SIG_M      = 8'h4D;

    // Row size in bytes, padded up to a multiple of four as BMP requires.
    function automatic logic [31:0] stride_bytes(input logic [31:0] w, input logic bpp32);
        logic [31:0] raw;
        raw = bpp32 ? (w << 2) : (w + (w << 1));
        return (raw + 32'd3) & ~32'd3;
    endfunction

endpackage

// File: rtl/bmp_header_rom.sv
// Combinational lookup of one header byte by index from the registered header fields.
module bmp_header_rom
    import bmp_pkg::*;
(
    input  logic [7:0]  idx_i,
    input  logic [31:0] fsize_i,
    input  logic [31:0] width_i,
    input  logic [31:0] height_i,
    input  logic [31:0] img_i,
    input  logic        bpp32_i,
    output logic [7:0]  byte_o
);

    // Picks the little-endian byte of a 32-bit field that starts at header offset 'base'.
    function automatic logic [7:0] pick(input logic [31:0] v, input logic [7:0] idx,
                                        input logic [7:0] base);
        logic [7:0] off;
        off = idx - base;
        return v[{off[1:0], 3'b000} +: 8];
    endfunction

    // Byte map of the 54-byte file + info header; anything not listed is zero.
    always_comb begin
        byte_o = 8'h00;
        case (idx_i) inside
            8'd0:          byte_o = SIG_B;
            8'd1:          byte_o = SIG_M;
            [8'd2:8'd5]:   byte_o = pick(fsize_i, idx_i, 8'd2);
            [8'd10:8'd13]: byte_o = pick(PIX_OFFSET, idx_i, 8'd10);
            [8'd14:8'd17]: byte_o = pick(DIB_SIZE, idx_i, 8'd14);
            [8'd18:8'd21]: byte_o = pick(width_i, idx_i, 8'd18);
            [8'd22:8'd25]: byte_o = pick(height_i, idx_i, 8'd22);
            8'd26:         byte_o = 8'h01;
            8'd28:         byte_o = bpp32_i ? 8'd32 : 8'd24;
            [8'd34:8'd37]: byte_o = pick(img_i, idx_i, 8'd34);
            default:       byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/bmp_header_writer.sv
// Writes the BMP header for a cropped window as packed little-endian words into memory.
module bmp_header_writer
    import bmp_pkg::*;
#(
    parameter int                ADDR_W    = 24,
    parameter int                DATA_W    = 16,
    parameter int                COORD_W   = 11,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [COORD_W-1:0]    xMin,
    input  logic [COORD_W-1:0]    xMax,
    input  logic [COORD_W-1:0]    yMin,
    input  logic [COORD_W-1:0]    yMax,
    input  logic                  bpp32,
    input  logic                  top_down,
    input  logic                  wait_req,
    output logic [ADDR_W-1:0]     addr,
    output logic                  wren,
    output logic [DATA_W-1:0]     wrdata,
    output logic [DATA_W/8-1:0]   byteen,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int         BPW    = DATA_W / 8;
    localparam int         NW     = (HDR_BYTES + BPW - 1) / BPW;
    localparam logic [5:0] LAST_K = 6'(NW - 1);

    state_e               state_q, state_d;
    logic [5:0]           k_q, k_d;
    logic [COORD_W-1:0]   xMin_q, xMax_q, yMin_q, yMax_q;
    logic                 bpp32_q, topDown_q;
    logic [31:0]          width_q, height_q, img_q, fsize_q;
    logic                 err_q;

    logic [31:0]          wCalc, hCalc, strideCalc, imgCalc;
    logic                 winBad;
    logic [7:0]           byteIdx [BPW];
    logic [7:0]           romByte [BPW];

    // Header arithmetic from the snapshot; registered during the single CALC cycle.
    always_comb begin
        wCalc      = 32'(xMax_q) - 32'(xMin_q) + 32'd1;
        hCalc      = 32'(yMax_q) - 32'(yMin_q) + 32'd1;
        strideCalc = stride_bytes(wCalc, bpp32_q);
        imgCalc    = strideCalc * hCalc;
        winBad     = (xMax_q < xMin_q) || (yMax_q < yMin_q);
    end

    // State and word counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    // Input snapshot taken when a request is accepted, so later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xMin_q    <= '0;
            xMax_q    <= '0;
            yMin_q    <= '0;
            yMax_q    <= '0;
            bpp32_q   <= 1'b0;
            topDown_q <= 1'b0;
        end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
            xMin_q    <= xMin;
            xMax_q    <= xMax;
            yMin_q    <= yMin;
            yMax_q    <= yMax;
            bpp32_q   <= bpp32;
            topDown_q <= top_down;
        end
    end

    // Field registers and the window-error flag, loaded once per request in CALC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_q  <= '0;
            height_q <= '0;
            img_q    <= '0;
            fsize_q  <= '0;
            err_q    <= 1'b0;
        end else if (state_q == S_CALC) begin
            width_q  <= wCalc;
            height_q <= topDown_q ? (32'd0 - hCalc) : hCalc;
            img_q    <= imgCalc;
            fsize_q  <= imgCalc + PIX_OFFSET;
            err_q    <= winBad;
        end
    end

    // Next-state logic: a stalled word keeps k, an accepted one advances it.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_CALC;
            end
            S_CALC: begin
                k_d     = '0;
                state_d = winBad ? S_DONE : S_WRITE;
            end
            S_WRITE: begin
                if (!wait_req) begin
                    if (k_q == LAST_K) begin
                        state_d = S_DONE;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                k_d     = '0;
            end
        endcase
    end

    // One byte lookup per lane of the current word.
    for (genvar j = 0; j < BPW; j++) begin : g_lane
        assign byteIdx[j] = 8'(k_q) * 8'(BPW) + 8'(j);
        bmp_header_rom u_rom (
            .idx_i    (byteIdx[j]),
            .fsize_i  (fsize_q),
            .width_i  (width_q),
            .height_i (height_q),
            .img_i    (img_q),
            .bpp32_i  (bpp32_q),
            .byte_o   (romByte[j])
        );
    end

    // Bus outputs are only driven while writing; lanes past the header end are disabled.
    always_comb begin
        wren   = (state_q == S_WRITE);
        busy   = (state_q == S_CALC) || (state_q == S_WRITE);
        done   = (state_q == S_DONE);
        err    = (state_q == S_DONE) && err_q;
        addr   = '0;
        wrdata = '0;
        byteen = '0;
        if (state_q == S_WRITE) begin
            addr = BASE_ADDR + ADDR_W'(k_q);
            for (int j = 0; j < BPW; j++) begin
                wrdata[8*j +: 8] = romByte[j];
                byteen[j]        = (byteIdx[j] < 8'(HDR_BYTES));
            end
        end
    end

endmodule
